// File: rtl/ac97_frame_tx.sv
// AC97 transmit framer: slot-0 tag, slot 1/2 codec command, slot 3/4 PCM, 48 kHz strobe.
// Optional mute input under `AC97_TX_MUTE_EN`; SYNC/SDATA_OUT lag bit_cnt by one cycle.
module ac97_frame_tx #(
  parameter bit TAG_PCM_EN   = 1'b1,
  parameter int SAMPLE_SHIFT = 0
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [19:0] I_LEFT_SAMPLE,
  input  logic [19:0] I_RIGHT_SAMPLE,
  input  logic        I_CMD_VALID,
  input  logic        I_CMD_RD,
  input  logic [6:0]  I_CMD_ADDR,
  input  logic [15:0] I_CMD_DATA,
`ifdef AC97_TX_MUTE_EN
  input  logic        I_MUTE,
`endif
  output logic        O_CMD_READY,
  output logic        O_SYNC,
  output logic        O_SDATA_OUT,
  output logic        O_STROBE
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SENDING = 2'd2
  } cmd_state_t;

  cmd_state_t  state;
  logic [7:0]  bit_cnt;
  logic [19:0] left_q;
  logic [19:0] right_q;
  logic        cmd_rd;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;

  logic        frame_end;
  logic        mute;
  logic        sending;
  logic [15:0] tag;
  logic [19:0] slot1;
  logic [19:0] slot2;
  logic [95:0] frame_hi;
  logic        frame_bit;
  logic [19:0] left_next;
  logic [19:0] right_next;

`ifdef AC97_TX_MUTE_EN
  assign mute = I_MUTE;
`else
  assign mute = 1'b0;
`endif

  assign frame_end = (bit_cnt == 8'd255);
  assign sending   = (state == ST_SENDING);

  assign left_next  = mute ? 20'h0 : (I_LEFT_SAMPLE >> SAMPLE_SHIFT);
  assign right_next = mute ? 20'h0 : (I_RIGHT_SAMPLE >> SAMPLE_SHIFT);

  // Only the first 96 frame bits carry data; slots 5..12 are always zero.
  always_comb begin
    tag       = 16'h8000;
    tag[14]   = sending;
    tag[13]   = sending & ~cmd_rd;
    tag[12]   = TAG_PCM_EN;
    tag[11]   = TAG_PCM_EN;
    slot1     = {cmd_rd, cmd_addr, 12'h000};
    slot2     = cmd_rd ? 20'h0 : {cmd_data, 4'h0};
    frame_hi  = {tag, slot1, slot2, left_q, right_q};
    frame_bit = 1'b0;
    if (bit_cnt < 8'd96) begin
      frame_bit = frame_hi[7'd95 - bit_cnt[6:0]];
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      bit_cnt     <= 8'd0;
      O_SYNC      <= 1'b0;
      O_SDATA_OUT <= 1'b0;
      O_STROBE    <= 1'b0;
      O_CMD_READY <= 1'b1;
      state       <= ST_IDLE;
      left_q      <= 20'h0;
      right_q     <= 20'h0;
      cmd_rd      <= 1'b0;
      cmd_addr    <= 7'h0;
      cmd_data    <= 16'h0;
    end else begin
      bit_cnt     <= bit_cnt + 8'd1;
      O_SYNC      <= (bit_cnt <= 8'd15);
      O_SDATA_OUT <= frame_bit;
      O_STROBE    <= frame_end;

      if (frame_end) begin
        left_q  <= left_next;
        right_q <= right_next;
      end

      // A command accepted on the last bit still waits a full frame in PENDING.
      case (state)
        ST_IDLE: begin
          if (I_CMD_VALID) begin
            cmd_rd      <= I_CMD_RD;
            cmd_addr    <= I_CMD_ADDR;
            cmd_data    <= I_CMD_DATA;
            state       <= ST_PENDING;
            O_CMD_READY <= 1'b0;
          end
        end
        ST_PENDING: begin
          if (frame_end) begin
            state <= ST_SENDING;
          end
        end
        ST_SENDING: begin
          if (frame_end) begin
            state       <= ST_IDLE;
            O_CMD_READY <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          O_CMD_READY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Directed bench for ac97_frame_tx: reassembles frames from SYNC/SDATA_OUT and checks slots.
module tb_ac97_frame_tx;

  logic        I_CLK = 1'b0;
  logic        I_RESET = 1'b1;
  logic [19:0] I_LEFT_SAMPLE = 20'h0;
  logic [19:0] I_RIGHT_SAMPLE = 20'h0;
  logic        I_CMD_VALID = 1'b0;
  logic        I_CMD_RD = 1'b0;
  logic [6:0]  I_CMD_ADDR = 7'h0;
  logic [15:0] I_CMD_DATA = 16'h0;
`ifdef AC97_TX_MUTE_EN
  logic        I_MUTE = 1'b0;
`endif
  logic        O_CMD_READY;
  logic        O_SYNC;
  logic        O_SDATA_OUT;
  logic        O_STROBE;

  ac97_frame_tx dut (
    .I_CLK          (I_CLK),
    .I_RESET        (I_RESET),
    .I_LEFT_SAMPLE  (I_LEFT_SAMPLE),
    .I_RIGHT_SAMPLE (I_RIGHT_SAMPLE),
    .I_CMD_VALID    (I_CMD_VALID),
    .I_CMD_RD       (I_CMD_RD),
    .I_CMD_ADDR     (I_CMD_ADDR),
    .I_CMD_DATA     (I_CMD_DATA),
`ifdef AC97_TX_MUTE_EN
    .I_MUTE         (I_MUTE),
`endif
    .O_CMD_READY    (O_CMD_READY),
    .O_SYNC         (O_SYNC),
    .O_SDATA_OUT    (O_SDATA_OUT),
    .O_STROBE       (O_STROBE)
  );

  always #5 I_CLK = ~I_CLK;

  // d/s/st hold SDATA/SYNC/STROBE; frame bit k lands at index 255-k.
  typedef struct {
    logic [255:0] d;
    logic [255:0] s;
    logic [255:0] st;
  } frame_t;

  frame_t frames[$];
  frame_t cur;
  int     idx = -1;
  logic   prev_sync = 1'b0;
  int     checks = 0;
  int     errors = 0;
  int     pos = 0;

  always @(negedge I_CLK) begin
    if (I_RESET) begin
      idx       = -1;
      prev_sync = 1'b0;
    end else begin
      if (O_SYNC && !prev_sync) begin
        idx    = 0;
        cur.d  = '0;
        cur.s  = '0;
        cur.st = '0;
      end
      prev_sync = O_SYNC;
      if (idx >= 0) begin
        cur.d[255-idx]  = O_SDATA_OUT;
        cur.s[255-idx]  = O_SYNC;
        cur.st[255-idx] = O_STROBE;
        if (idx == 255) begin
          frames.push_back(cur);
          idx = -1;
        end else begin
          idx++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pos tracks the DUT bit counter: inputs driven now are sampled on the edge with bit_cnt == pos.
  task automatic tick();
    @(negedge I_CLK);
    pos = (pos + 1) % 256;
  endtask

  task automatic goto_pos(input int p);
    while (pos != p) tick();
  endtask

  task automatic wait_frames(input int n);
    int budget;
    budget = 0;
    while (frames.size() < n && budget < 1500) begin
      tick();
      budget++;
    end
    chk("frames_seen", 256'(frames.size() >= n), 256'd1);
  endtask

  task automatic send_cmd(input logic rd, input logic [6:0] addr, input logic [15:0] data);
    I_CMD_VALID = 1'b1;
    I_CMD_RD    = rd;
    I_CMD_ADDR  = addr;
    I_CMD_DATA  = data;
    tick();
    I_CMD_VALID = 1'b0;
  endtask

  task automatic release_reset();
    I_RESET = 1'b0;
    pos     = 0;
    frames.delete();
  endtask

  initial begin
    logic [255:0] sync_mask;
    sync_mask = {16'hFFFF, 240'h0};

    // Reset values
    I_LEFT_SAMPLE  = 20'hABCDE;
    I_RIGHT_SAMPLE = 20'h12345;
    repeat (3) tick();
    chk("rst_sync", 256'(O_SYNC), 256'd0);
    chk("rst_sdata", 256'(O_SDATA_OUT), 256'd0);
    chk("rst_strobe", 256'(O_STROBE), 256'd0);
    chk("rst_ready", 256'(O_CMD_READY), 256'd1);

    release_reset();
    tick();
    chk("first_sync", 256'(O_SYNC), 256'd1);
    chk("first_sdata", 256'(O_SDATA_OUT), 256'd1);

    // Idle frames: first carries zero PCM, then ABCDE/12345
    wait_frames(3);
    chk("f0_tag", 256'(frames[0].d[255:240]), 256'h9800);
    chk("f0_slot3", 256'(frames[0].d[199:180]), 256'h0);
    chk("f0_slot4", 256'(frames[0].d[179:160]), 256'h0);
    chk("f0_strobe", frames[0].st, 256'd1);
    chk("f1_tag", 256'(frames[1].d[255:240]), 256'h9800);
    chk("f1_slot3", 256'(frames[1].d[199:180]), 256'hABCDE);
    chk("f1_slot4", 256'(frames[1].d[179:160]), 256'h12345);
    chk("f1_sync", frames[1].s, sync_mask);
    chk("f1_strobe", frames[1].st, 256'd1);
    chk("f1_tail", 256'(frames[1].d[159:0]), 256'h0);
    chk("f2_sync", frames[2].s, sync_mask);
    chk("f2_strobe", frames[2].st, 256'd1);
    chk("f2_slot3", 256'(frames[2].d[199:180]), 256'hABCDE);

    // Write command accepted mid-frame; a second request while busy is dropped
    goto_pos(100);
    frames.delete();
    chk("wr_ready_before", 256'(O_CMD_READY), 256'd1);
    send_cmd(1'b0, 7'h02, 16'h0808);
    chk("wr_ready_low", 256'(O_CMD_READY), 256'd0);
    goto_pos(200);
    send_cmd(1'b1, 7'h7F, 16'hFFFF);
    wait_frames(1);
    chk("wr_ready_sending", 256'(O_CMD_READY), 256'd0);
    goto_pos(255);
    chk("wr_ready_last", 256'(O_CMD_READY), 256'd0);
    tick();
    chk("wr_ready_back", 256'(O_CMD_READY), 256'd1);
    wait_frames(3);
    chk("wr_f0_tag", 256'(frames[0].d[255:240]), 256'h9800);
    chk("wr_tag", 256'(frames[1].d[255:240]), 256'hF800);
    chk("wr_slot1", 256'(frames[1].d[239:220]), 256'h02000);
    chk("wr_slot2", 256'(frames[1].d[219:200]), 256'h08080);
    chk("wr_after_tag", 256'(frames[2].d[255:240]), 256'h9800);

    // Read command
    goto_pos(10);
    frames.delete();
    send_cmd(1'b1, 7'h26, 16'hFFFF);
    wait_frames(2);
    chk("rd_tag", 256'(frames[1].d[255:240]), 256'hD800);
    chk("rd_slot1", 256'(frames[1].d[239:220]), 256'hA6000);
    chk("rd_slot2", 256'(frames[1].d[219:200]), 256'h0);

    // Command accepted on the bit 255 edge is delayed one whole frame
    goto_pos(200);
    frames.delete();
    goto_pos(255);
    send_cmd(1'b0, 7'h15, 16'h1234);
    chk("edge_ready_low", 256'(O_CMD_READY), 256'd0);
    wait_frames(3);
    chk("edge_next_tag", 256'(frames[1].d[255:240]), 256'h9800);
    chk("edge_cmd_tag", 256'(frames[2].d[255:240]), 256'hF800);
    chk("edge_cmd_slot1", 256'(frames[2].d[239:220]), 256'h15000);
    chk("edge_cmd_slot2", 256'(frames[2].d[219:200]), 256'h12340);

    // Sample change mid-frame
    goto_pos(50);
    I_LEFT_SAMPLE = 20'h11111;
    goto_pos(10);
    frames.delete();
    goto_pos(100);
    I_LEFT_SAMPLE = 20'h22222;
    wait_frames(2);
    chk("mid_cur_slot3", 256'(frames[0].d[199:180]), 256'h11111);
    chk("mid_next_slot3", 256'(frames[1].d[199:180]), 256'h22222);
    chk("mid_next_slot4", 256'(frames[1].d[179:160]), 256'h12345);

    // Reset mid-frame with a command pending
    goto_pos(30);
    send_cmd(1'b0, 7'h01, 16'h5555);
    chk("pend_ready_low", 256'(O_CMD_READY), 256'd0);
    goto_pos(60);
    I_RESET = 1'b1;
    tick();
    chk("mrst_sync", 256'(O_SYNC), 256'd0);
    chk("mrst_sdata", 256'(O_SDATA_OUT), 256'd0);
    chk("mrst_strobe", 256'(O_STROBE), 256'd0);
    chk("mrst_ready", 256'(O_CMD_READY), 256'd1);
    tick();
    release_reset();
    tick();
    chk("mrst_first_sync", 256'(O_SYNC), 256'd1);
    chk("mrst_first_sdata", 256'(O_SDATA_OUT), 256'd1);
    wait_frames(2);
    chk("mrst_f0_tag", 256'(frames[0].d[255:240]), 256'h9800);
    chk("mrst_f0_slot3", 256'(frames[0].d[199:180]), 256'h0);
    chk("mrst_f0_slot4", 256'(frames[0].d[179:160]), 256'h0);
    chk("mrst_f1_tag", 256'(frames[1].d[255:240]), 256'h9800);
    chk("mrst_f1_slot3", 256'(frames[1].d[199:180]), 256'h22222);

`ifdef AC97_TX_MUTE_EN
    I_MUTE = 1'b1;
    goto_pos(10);
    frames.delete();
    wait_frames(2);
    chk("mute_slot3", 256'(frames[1].d[199:180]), 256'h0);
    chk("mute_slot4", 256'(frames[1].d[179:160]), 256'h0);
    chk("mute_tag", 256'(frames[1].d[255:240]), 256'h9800);
    I_MUTE = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
